// File: rtl/laser_pkg.sv
// laser_pkg: shared state encoding, count-width helper and default radius
// for the laser_cover_engine two-circle coverage search.
package laser_pkg;

  typedef enum logic [2:0] {
    S_LOAD,
    S_SCAN1,
    S_SCAN2,
    S_EVAL,
    S_FIN
  } state_t;

  localparam int DEF_RADIUS = 4;
  localparam int RADIUS_SQ  = DEF_RADIUS * DEF_RADIUS;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/laser_cover_count.sv
// laser_cover_count: combinational union popcount of points covered by
// a candidate centre or a fixed centre.
module laser_cover_count
  import laser_pkg::*;
#(
  parameter int NPTS = 40,
  parameter int CW   = 4,
  parameter int RSQ  = RADIUS_SQ,
  parameter int CNW  = cnt_width(NPTS)
) (
  input  logic [CW-1:0]            cx,
  input  logic [CW-1:0]            cy,
  input  logic [CW-1:0]            fx,
  input  logic [CW-1:0]            fy,
  input  logic [NPTS-1:0][CW-1:0]  px,
  input  logic [NPTS-1:0][CW-1:0]  py,
  output logic [CNW-1:0]           cnt
);

  // dx/dy widened to CW+1 signed, squares to 2*CW+2 so edges never wrap
  function automatic logic hit(
    input logic [CW-1:0] ax,
    input logic [CW-1:0] ay,
    input logic [CW-1:0] bx,
    input logic [CW-1:0] by
  );
    logic signed [CW:0]      dx;
    logic signed [CW:0]      dy;
    logic signed [2*CW+1:0]  sx;
    logic signed [2*CW+1:0]  sy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    sx = dx * dx;
    sy = dy * dy;
    return (sx + sy) <= $signed((2*CW+2)'(RSQ));
  endfunction

  // one adder chain across all points, each point counted once
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NPTS; i++) begin
      if (hit(px[i], py[i], cx, cy) || hit(px[i], py[i], fx, fy))
        cnt = cnt + 1'b1;
    end
  end

endmodule

// File: rtl/laser_cover_engine.sv
// laser_cover_engine: loads NPTS points, alternates exhaustive scans for two
// centres. Optional COVER output enabled by macro LASER_COVER_OUT_EN.
module laser_cover_engine
  import laser_pkg::*;
#(
  parameter int NPTS       = 40,
  parameter int CW         = 4,
  parameter int RADIUS     = DEF_RADIUS,
  parameter int MAX_ROUNDS = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [CW-1:0]               X,
  input  logic [CW-1:0]               Y,
  output logic [CW-1:0]               C1X,
  output logic [CW-1:0]               C1Y,
  output logic [CW-1:0]               C2X,
  output logic [CW-1:0]               C2Y,
  output logic                        DONE
`ifdef LASER_COVER_OUT_EN
  ,
  output logic [cnt_width(NPTS)-1:0]  COVER
`endif
);

  localparam int CNW = cnt_width(NPTS);
  localparam int IW  = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int RW  = $clog2(MAX_ROUNDS + 1);
  localparam int RSQ = RADIUS * RADIUS;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic [RW-1:0]            round;
  logic [RW-1:0]            round_nx;
  logic [CNW-1:0]           best;
  logic [CNW-1:0]           cnt;
  logic                     improved;
  logic [2*CW-1:0]          cand;
  logic [CW-1:0]            cx;
  logic [CW-1:0]            cy;
  logic [CW-1:0]            c1x;
  logic [CW-1:0]            c1y;
  logic [CW-1:0]            c2x;
  logic [CW-1:0]            c2y;
  logic [CW-1:0]            fx;
  logic [CW-1:0]            fy;
  logic                     stop;
  logic [NPTS-1:0][CW-1:0]  px;
  logic [NPTS-1:0][CW-1:0]  py;

  assign cx       = cand[CW-1:0];
  assign cy       = cand[2*CW-1:CW];
  assign fx       = (state == S_SCAN1) ? c2x : c1x;
  assign fy       = (state == S_SCAN1) ? c2y : c1y;
  assign round_nx = round + 1'b1;
  assign stop     = !improved
                 || (round_nx == RW'(MAX_ROUNDS))
                 || (best == CNW'(NPTS));

  laser_cover_count #(
    .NPTS (NPTS),
    .CW   (CW),
    .RSQ  (RSQ),
    .CNW  (CNW)
  ) u_count (
    .cx  (cx),
    .cy  (cy),
    .fx  (fx),
    .fy  (fy),
    .px  (px),
    .py  (py),
    .cnt (cnt)
  );

  // sequencer: load, alternate scans, evaluate, publish result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_LOAD;
      idx      <= '0;
      round    <= '0;
      best     <= '0;
      improved <= 1'b0;
      cand     <= '0;
      c1x      <= '0;
      c1y      <= '0;
      c2x      <= '0;
      c2y      <= '0;
      px       <= '0;
      py       <= '0;
      C1X      <= '0;
      C1Y      <= '0;
      C2X      <= '0;
      C2Y      <= '0;
      DONE     <= 1'b0;
`ifdef LASER_COVER_OUT_EN
      COVER    <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_LOAD: begin
          px[idx] <= X;
          py[idx] <= Y;
          if (idx == IW'(NPTS - 1)) begin
            idx   <= '0;
            state <= S_SCAN1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_SCAN1: begin
          if (cnt > best) begin
            c1x      <= cx;
            c1y      <= cy;
            best     <= cnt;
            improved <= 1'b1;
          end
          cand <= cand + 1'b1;
          if (&cand) state <= S_SCAN2;
        end
        S_SCAN2: begin
          if (cnt > best) begin
            c2x      <= cx;
            c2y      <= cy;
            best     <= cnt;
            improved <= 1'b1;
          end
          cand <= cand + 1'b1;
          if (&cand) state <= S_EVAL;
        end
        S_EVAL: begin
          round <= round_nx;
          if (stop) begin
            C1X   <= c1x;
            C1Y   <= c1y;
            C2X   <= c2x;
            C2Y   <= c2y;
            DONE  <= 1'b1;
`ifdef LASER_COVER_OUT_EN
            COVER <= best;
`endif
            state <= S_FIN;
          end else begin
            improved <= 1'b0;
            state    <= S_SCAN1;
          end
        end
        S_FIN: begin
          best     <= '0;
          round    <= '0;
          idx      <= '0;
          improved <= 1'b0;
          cand     <= '0;
          c1x      <= '0;
          c1y      <= '0;
          c2x      <= '0;
          c2y      <= '0;
          state    <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_engine.sv
// tb_laser_cover_engine: directed datasets with hand-computed results and a
// behavioural reference model for the multi-round case.
module tb_laser_cover_engine;

  localparam int NPTS = 40;
  localparam int CW   = 4;
  localparam int RSQ  = 16;
  localparam int SCAN = 2 * (1 << (2 * CW)) + 1;
  localparam int LIM  = 3000;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [CW-1:0]  X = '0;
  logic [CW-1:0]  Y = '0;
  logic [CW-1:0]  C1X;
  logic [CW-1:0]  C1Y;
  logic [CW-1:0]  C2X;
  logic [CW-1:0]  C2Y;
  logic           DONE;
`ifdef LASER_COVER_OUT_EN
  logic [5:0]     COVER;
`endif

  int total = 0;
  int bad   = 0;
  int px [NPTS];
  int py [NPTS];
  int m1x, m1y, m2x, m2y, mbest, mrounds;

  laser_cover_engine dut (
    .CLK   (CLK),
    .RST   (RST),
    .X     (X),
    .Y     (Y),
    .C1X   (C1X),
    .C1Y   (C1Y),
    .C2X   (C2X),
    .C2Y   (C2Y),
    .DONE  (DONE)
`ifdef LASER_COVER_OUT_EN
    ,
    .COVER (COVER)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NPTS; i++) begin
      case (kind)
        0: begin px[i] = 5; py[i] = 5; end
        1: begin
          px[i] = (i < 20) ? 2 : 13;
          py[i] = (i < 20) ? 2 : 13;
        end
        2: begin px[i] = 15; py[i] = 15; end
        default: begin
          if (i < 13)      begin px[i] = 0;  py[i] = 0;  end
          else if (i < 26) begin px[i] = 15; py[i] = 0;  end
          else if (i < 39) begin px[i] = 0;  py[i] = 15; end
          else             begin px[i] = 8;  py[i] = 8;  end
        end
      endcase
    end
  endtask

  task automatic stream();
    for (int i = 0; i < NPTS; i++) begin
      X = CW'(px[i]);
      Y = CW'(py[i]);
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int cov(input int ax, input int ay,
                             input int bx, input int by);
    int n = 0;
    for (int i = 0; i < NPTS; i++) begin
      if ((px[i]-ax)*(px[i]-ax) + (py[i]-ay)*(py[i]-ay) <= RSQ ||
          (px[i]-bx)*(px[i]-bx) + (py[i]-by)*(py[i]-by) <= RSQ)
        n++;
    end
    return n;
  endfunction

  task automatic model();
    int imp;
    int n;
    m1x = 0; m1y = 0; m2x = 0; m2y = 0; mbest = 0; mrounds = 0;
    forever begin
      imp = 0;
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) begin
          n = cov(x, y, m2x, m2y);
          if (n > mbest) begin m1x = x; m1y = y; mbest = n; imp = 1; end
        end
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) begin
          n = cov(x, y, m1x, m1y);
          if (n > mbest) begin m2x = x; m2y = y; mbest = n; imp = 1; end
        end
      mrounds++;
      if (imp == 0 || mrounds == 4 || mbest == NPTS) break;
    end
  endtask

  task automatic check_run(input string tag, input int ecyc,
                           input int e1x, input int e1y,
                           input int e2x, input int e2y, input int ecov);
    int cyc = NPTS;
    while (DONE !== 1'b1 && cyc < LIM) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, ecyc);
    chk({tag, "_c1x"}, C1X, e1x);
    chk({tag, "_c1y"}, C1Y, e1y);
    chk({tag, "_c2x"}, C2X, e2x);
    chk({tag, "_c2y"}, C2Y, e2y);
`ifdef LASER_COVER_OUT_EN
    chk({tag, "_cover"}, COVER, ecov);
`else
    if (ecov < 0) chk({tag, "_cover_arg"}, ecov, 0);
`endif
    @(posedge CLK);
    #1;
    chk({tag, "_done_width"}, DONE, 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_done", DONE, 0);
    chk("rst_c1x", C1X, 0);
    chk("rst_c1y", C1Y, 0);
    chk("rst_c2x", C2X, 0);
    chk("rst_c2y", C2Y, 0);
`ifdef LASER_COVER_OUT_EN
    chk("rst_cover", COVER, 0);
`endif
    RST = 1'b0;

    fill(0);
    stream();
    check_run("p55", 553, 5, 1, 0, 0, 40);

    fill(2);
    stream();
    check_run("p1515_b2b", 553, 15, 11, 0, 0, 40);

    fill(1);
    stream();
    check_run("split", 553, 13, 9, 0, 0, 40);

    chk("hold_c1x", C1X, 13);
    fill(0);
    stream();
    repeat (260) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_done", DONE, 0);
    chk("arst_c1x", C1X, 0);
    chk("arst_c1y", C1Y, 0);
    chk("arst_c2x", C2X, 0);
    chk("arst_c2y", C2Y, 0);
`ifdef LASER_COVER_OUT_EN
    chk("arst_cover", COVER, 0);
`endif
    @(posedge CLK);
    #1;
    RST = 1'b0;
    stream();
    check_run("reload", 553, 5, 1, 0, 0, 40);

    fill(3);
    model();
    stream();
    check_run("corners", NPTS + mrounds * SCAN,
              m1x, m1y, m2x, m2y, mbest);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
